// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Latches an instruction on run and walks the 4-bit step codes
//             consumed by the control decoder, then signals completion.
//             Optional macro SEQ_SINGLE_STEP_EN adds a 'step' gating input.
//  Revision : 1.0  initial release
// ============================================================================
module instr_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [DATA_W-1:0] din,
    output logic [3:0]        state,
    output logic [DATA_W-1:0] ir,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOAD   = 4'd2,
        S_MOVE   = 4'd3,
        S_LDPC   = 4'd4,
        S_BRANCH = 4'd5,
        S_SUB0   = 4'd6,
        S_SUB1   = 4'd7,
        S_SUB2   = 4'd8,
        S_ADD0   = 4'd9,
        S_ADD1   = 4'd10,
        S_ADD2   = 4'd11,
        S_XOR0   = 4'd12,
        S_XOR1   = 4'd13,
        S_XOR2   = 4'd14
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_ir;
    logic                r_busy;
    logic                r_done;
    logic                r_illegal;
    logic [CNT_W-1:0]    r_count;
    logic                w_advance;
    logic                w_illegal_op;
    logic                w_accept;
    logic                w_finish;
    logic                w_retire;
    logic [3:0]          w_opcode;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_advance = step;
`else
    assign w_advance = 1'b1;
`endif

    assign w_opcode = r_ir[DATA_W-1 -: 4];

    always_comb begin
        w_next_state = r_state;
        w_illegal_op = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_advance) begin
                    case (w_opcode)
                        4'd0:    w_next_state = S_LOAD;
                        4'd1:    w_next_state = S_MOVE;
                        4'd2:    w_next_state = S_LDPC;
                        4'd3:    w_next_state = S_BRANCH;
                        4'd4:    w_next_state = S_SUB0;
                        4'd5:    w_next_state = S_ADD0;
                        4'd6:    w_next_state = S_XOR0;
                        default: begin
                            w_next_state = S_IDLE;
                            w_illegal_op = 1'b1;
                        end
                    endcase
                end
            end
            S_SUB0: if (w_advance) w_next_state = S_SUB1;
            S_SUB1: if (w_advance) w_next_state = S_SUB2;
            S_ADD0: if (w_advance) w_next_state = S_ADD1;
            S_ADD1: if (w_advance) w_next_state = S_ADD2;
            S_XOR0: if (w_advance) w_next_state = S_XOR1;
            S_XOR1: if (w_advance) w_next_state = S_XOR2;
            S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_SUB2, S_ADD2, S_XOR2: begin
                if (w_advance) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && run;
    // Any non-IDLE state falling back to IDLE ends an instruction, legal or not.
    assign w_finish = (r_state != S_IDLE) && (w_next_state == S_IDLE);
    assign w_retire = w_finish && !w_illegal_op;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= w_finish;
            if (w_accept) begin
                r_ir      <= din;
                r_illegal <= 1'b0;
            end else if (w_illegal_op) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) r_count <= r_count + 1'b1;
        end
    end

    assign state       = r_state;
    assign ir          = r_ir;
    assign busy        = r_busy;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Self-checking bench for instr_sequencer (vector table plus
//             per-cycle expectation queue).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_sequencer;

    logic        clock;
    logic        resetn;
    logic        run;
    logic        step;
    logic [15:0] din;
    logic [3:0]  state;
    logic [15:0] ir;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [7:0]  instr_count;

    instr_sequencer #(.DATA_W(16), .CNT_W(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .run         (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .din         (din),
        .state       (state),
        .ir          (ir),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  state;
        logic        busy;
        logic        done;
        logic        illegal;
        logic [15:0] ir;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        int          busy_cycles;
        logic        illegal;
    } vec_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_cnt    = 8'd0;
    logic        m_ill    = 1'b0;
    int          busy_seen;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expected per-cycle outputs for one accepted instruction.
    task automatic push_instr(input logic [15:0] w);
        logic [3:0] codes [4];
        int         n;
        exp_t       e;
        codes[0] = 4'd1;
        codes[1] = 4'd0;
        codes[2] = 4'd0;
        codes[3] = 4'd0;
        n = 1;
        case (w[15:12])
            4'd0: begin codes[1] = 4'd2; n = 2; end
            4'd1: begin codes[1] = 4'd3; n = 2; end
            4'd2: begin codes[1] = 4'd4; n = 2; end
            4'd3: begin codes[1] = 4'd5; n = 2; end
            4'd4: begin codes[1] = 4'd6;  codes[2] = 4'd7;  codes[3] = 4'd8;  n = 4; end
            4'd5: begin codes[1] = 4'd9;  codes[2] = 4'd10; codes[3] = 4'd11; n = 4; end
            4'd6: begin codes[1] = 4'd12; codes[2] = 4'd13; codes[3] = 4'd14; n = 4; end
            default: n = 1;
        endcase
        m_ill = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.state = codes[i]; e.busy = 1'b1; e.done = 1'b0;
            e.illegal = 1'b0; e.ir = w; e.cnt = m_cnt;
            sb.push_back(e);
        end
        if (w[15:12] >= 4'd7) m_ill = 1'b1;
        else                  m_cnt = m_cnt + 8'd1;
        e.state = 4'd0; e.busy = 1'b0; e.done = 1'b1;
        e.illegal = m_ill; e.ir = w; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: actual=empty required=entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            if ({state, busy, done, illegal, ir, instr_count} !==
                {e.state, e.busy, e.done, e.illegal, e.ir, e.cnt}) begin
                failures++;
                $display("FAIL cycle: actual st=%0h bsy=%0b dn=%0b ill=%0b ir=%0h cnt=%0h required st=%0h bsy=%0b dn=%0b ill=%0b ir=%0h cnt=%0h at %0t",
                         state, busy, done, illegal, ir, instr_count,
                         e.state, e.busy, e.done, e.illegal, e.ir, e.cnt, $time);
            end
        end
    endtask

    // Compare every cycle until the expectation queue is empty; ends in the done cycle.
    task automatic drain();
        busy_seen = 0;
        for (int guard = 0; guard < 16; guard++) begin
            if (busy) busy_seen++;
            check_pop();
            if (sb.size() == 0) break;
            tick();
        end
    endtask

    task automatic check_reset(input string name);
        check(name, {state, busy, done, illegal, ir, instr_count}, 32'd0);
    endtask

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        sel;
        logic [15:0] w;
        vecs[0] = '{16'h2300, 2, 1'b0};
        vecs[1] = '{16'h4120, 4, 1'b0};
        vecs[2] = '{16'hF000, 1, 1'b1};
        vecs[3] = '{16'h1120, 2, 1'b0};
        vecs[4] = '{16'h6340, 4, 1'b0};
        vecs[5] = '{16'h3001, 2, 1'b0};
        vecs[6] = '{16'h0000, 2, 1'b0};
        vecs[7] = '{16'h5ABC, 4, 1'b0};
        vecs[8] = '{16'h7FFF, 1, 1'b1};
        vecs[9] = '{16'h2222, 2, 1'b0};

        resetn = 1'b0; run = 1'b0; step = 1'b1; din = 16'hABCD;
        tick(); tick();
        check_reset("reset_state");
        resetn = 1'b1;
        tick();
        check_reset("idle_after_reset");

        // Table-driven single instructions, back-to-back from the done cycle.
        foreach (vecs[k]) begin
            run = 1'b1; din = vecs[k].din;
            tick();
            run = 1'b0; din = ~vecs[k].din;
            push_instr(vecs[k].din);
            drain();
            check("busy_cycles", busy_seen, vecs[k].busy_cycles);
            check("illegal_at_done", {31'd0, illegal}, {31'd0, vecs[k].illegal});
        end
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // run held high, alternating MOVE/XOR until the counter wraps.
        sel = 1'b0;
        run = 1'b1; din = 16'h1120;
        tick();
        for (int it = 0; it < 600; it++) begin
            w = sel ? 16'h6340 : 16'h1120;
            push_instr(w);
            sel = ~sel;
            din = sel ? 16'h6340 : 16'h1120;
            drain();
            if (m_cnt == 8'hFF) break;
            tick();
        end
        check("count_at_ff", {24'd0, instr_count}, 32'h0000_00FF);
        tick();
        push_instr(din);
        run = 1'b0;
        drain();
        check("count_wrap", {24'd0, instr_count}, 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
        begin
            logic [3:0] ss_codes [4];
            ss_codes[0] = 4'd1; ss_codes[1] = 4'd9; ss_codes[2] = 4'd10; ss_codes[3] = 4'd11;
            tick();
            step = 1'b0; run = 1'b1; din = 16'h5123;
            tick();
            run = 1'b0;
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 3; j++) begin
                    check("ss_state", {28'd0, state}, {28'd0, ss_codes[c]});
                    check("ss_busy_done", {30'd0, busy, done}, 32'd2);
                    step = (j == 2);
                    tick();
                end
            end
            step = 1'b1;
            m_cnt = m_cnt + 8'd1;
            check("ss_done", {state, busy, done, instr_count}, {4'd0, 1'b0, 1'b1, m_cnt});
        end
`endif

        // Asynchronous reset in the middle of ADD1.
        tick();
        run = 1'b1; din = 16'h5555;
        tick();
        run = 1'b0;
        tick(); tick();
        check("mid_add1_state", {28'd0, state}, 32'd10);
        #2;
        resetn = 1'b0;
        #1;
        check_reset("async_reset_mid_add1");
        tick();
        resetn = 1'b1;
        tick();
        check_reset("idle_after_async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-level step sequencer for the 16-bit CPU datapath.
- Accepts an instruction word on a run request and latches it into an instruction register.
- Emits the 4-bit step code consumed by the control-signal decoder, one code per cycle, then reports completion.
- Sits between the instruction source (memory/test harness) and the control decoder; owns all step timing.

Parameters:
DATA_W, 16, instruction/register width; opcode fixed at ir[15:12]
CNT_W, 8, width of retired-instruction counter

Ports:
clock  input  1  single system clock, rising-edge
resetn  input  1  asynchronous active-low reset
run  input  1  start request; sampled only in IDLE
din  input  DATA_W  instruction word; captured on accepted run
state  output  4  current step code to control decoder
ir  output  DATA_W  latched instruction register (drives decoder instr input)
busy  output  1  high from the cycle after an accepted run until the last exec step, inclusive
done  output  1  one-cycle pulse on return to IDLE after an instruction
illegal  output  1  set when a fetched opcode is undefined; sticky
instr_count  output  CNT_W  count of legal instructions retired

Behaviour:
- One clock; reset is asynchronous and active-low (resetn). Reset at any time, including mid-instruction, immediately forces:
  - state=0000, ir=0, busy=0, done=0, illegal=0, instr_count=0.
- All outputs are registered.
- Step codes:
  - 0000 IDLE
  - 0001 FETCH
  - 0010 LOAD
  - 0011 MOVE
  - 0100 LDPC
  - 0101 BRANCH
  - 0110/0111/1000 SUB0/1/2
  - 1001/1010/1011 ADD0/1/2
  - 1100/1101/1110 XOR0/1/2
  - 1111 unused, never emitted.
- IDLE:
  - If run=1 at the clock edge: ir<=din, state<=FETCH, busy<=1, illegal<=0.
  - Otherwise hold; ir holds its last value.
- FETCH: decode ir[15:12]:
  - 0 → LOAD
  - 1 → MOVE
  - 2 → LDPC
  - 3 → BRANCH
  - 4 → SUB0
  - 5 → ADD0
  - 6 → XOR0
  - 7–15 → IDLE, with done=1, illegal=1, busy=0; instr_count unchanged.
- Multi-step instructions:
  - SUB0→SUB1→SUB2
  - ADD0→ADD1→ADD2
  - XOR0→XOR1→XOR2
  - One step per cycle; no stalls.
- Last step (LOAD, MOVE, LDPC, BRANCH, SUB2, ADD2, XOR2): next state=IDLE, done=1 for exactly that IDLE cycle, busy=0, instr_count+1.
- Counter arithmetic: instr_count wraps modulo 2^CNT_W (all-ones+1 → 0).
- Latency from the run-sampled edge:
  - FETCH visible 1 cycle later.
  - Single-step instructions: done at cycle 3.
  - 3-step instructions: done at cycle 5.
- run is ignored while busy or in FETCH. din changes during execution have no effect.
- run=1 in the done cycle (state=IDLE) is accepted, giving back-to-back instructions with one IDLE cycle between them.
- run held high continuously issues a new instruction every (steps+2) cycles.
- ir is stable from FETCH through the done cycle.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - Transitions from FETCH and from every exec step occur only on edges where step=1; otherwise state holds and busy stays 1.
  - IDLE acceptance is unaffected by step.
- When undefined: no step port; sequencing is free-running as above.

Test Plan:
1. Reset mid-ADD1 (resetn low asynchronously) → state=0000, ir=0, busy=0, instr_count=0 before the next clock edge.
2. run=1, din=16'h2300 (LOAD) → FETCH(0001), LOAD(0010), then IDLE with done=1 on cycle 3; instr_count=1.
3. din=16'h4120 (SUB) → codes 0001,0110,0111,1000, then 0000 with done; busy high for 4 cycles.
4. din=16'hF000 → 0001 then 0000 with done=1, illegal=1, instr_count unchanged; next run clears illegal.
5. run held high, alternating MOVE(16'h1120)/XOR(16'h6340) → no missed or duplicated steps; 255 retirements then 1 more → instr_count wraps 0xFF→0x00.
6. SEQ_SINGLE_STEP_EN build, ADD with step pulsed every 3rd cycle → each step code held 3 cycles; done only after the final step.
